div_hilo_seq: RTL
=================

# div_hilo_seq

Multi-cycle divide sequencer that owns the divide path into the HI/LO register pair. It accepts a DIV/DIVU request from the execute stage and stalls the pipeline while it runs a 32-iteration restoring shift-subtract divide. It then presents {remainder, quotient} with a one-cycle HI/LO write strobe. It sits between the execute stage, the stall controller and the HI/LO register write port.

## Interface
- DATA_W, 32, operand width; the iteration count equals DATA_W.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  divide request from execute; held high until ready_o is seen.
- annul_i  in  1  cancel in-flight divide (flush or exception).
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend, sampled only on acceptance.
- opdata2_i  in  DATA_W  divisor, sampled only on acceptance.
- stall_o  out  1  pipeline stall request, combinational.
- ready_o  out  1  result valid.
- hilo_we_o  out  1  HI/LO write enable, one-cycle pulse.
- result_o  out  2*DATA_W  {HI = remainder, LO = quotient}.

## Operation
- States:
  - IDLE: waiting for a request.
  - BYZERO: only present with DIV_BYZERO_EN.
  - ON: iterating.
  - DONE: result held.
- IDLE:
  - start_i=1 and annul_i=0: latch |dividend| and |divisor| (absolute values only when signed_i=1), latch the sign flags, clear the iteration counter, go to ON.
  - With DIV_BYZERO_EN and divisor==0: go to BYZERO instead of ON.
- ON, one iteration per cycle, using a (2*DATA_W+1)-bit partial remainder:
  - Shift left by 1.
  - Trial-subtract the divisor from the upper half.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set bit 0.
  - After iteration DATA_W, go to DONE.
- Entry to DONE:
  - Quotient is negated if signed_i and the operand signs differ.
  - Remainder is negated if signed_i and the dividend is negative.
  - result_o registered; ready_o=1.
  - hilo_we_o=1 for the first DONE cycle only.
- DONE: stays in DONE while start_i=1 (result held, ready_o=1, hilo_we_o=0). Goes to IDLE the cycle after start_i=0; ready_o and result_o clear to 0.
- BYZERO: goes to DONE next cycle with result_o=0.
- annul_i=1 in ON or BYZERO:
  - Next state is IDLE; no hilo_we_o pulse.
  - result_o stays 0 and ready_o stays 0.
  - annul_i is ignored in DONE.
- Boundary cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (no trap).
  - Dividend 0 runs the full sequence and gives 0/0.
- stall_o = (IDLE & start_i & ~annul_i) | ON | BYZERO. It is 0 in DONE.

## Timing
- Reset: state IDLE, counter 0; ready_o, hilo_we_o and result_o all 0. Reset mid-operation aborts with no write.
- Normal latency: request in cycle 0, ON for cycles 1..32, DONE (ready_o, hilo_we_o) in cycle 33. stall_o is high in cycles 0..32.
- BYZERO latency: BYZERO in cycle 1, DONE in cycle 2.
- Back-to-back: a new request is accepted no earlier than the cycle after DONE→IDLE.
- Operands are latched only on the accepting edge; later changes on opdata* are ignored.

## Configuration
- DIV_BYZERO_EN defined: a zero divisor takes the BYZERO path. Latency is 2 cycles; result_o=0 and the HI/LO write still occurs.
- DIV_BYZERO_EN undefined: BYZERO does not exist. A zero divisor runs all DATA_W iterations and the natural result is written:
  - DIVU: LO=all ones, HI=dividend.
  - DIV: the sign rules are applied to that natural result.

## Test plan
- DIVU 100/7 → ready_o and hilo_we_o in cycle 33, HI=2, LO=14; stall_o high in cycles 0..32.
- DIV 0xFFFFFFF9(-7)/2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD; DIV 0x80000000/0xFFFFFFFF → HI=0, LO=0x80000000.
- DIVU 5/0 with DIV_BYZERO_EN → DONE in cycle 2, result 0. Without the macro → cycle 33, HI=5, LO=0xFFFFFFFF.
- annul_i pulsed in cycle 10 → IDLE in cycle 11, hilo_we_o never asserted, stall_o low from cycle 11.
- rst asserted in cycle 20 → all outputs 0 next cycle. A fresh DIVU 9/3 then gives HI=0, LO=3.
- start_i held 3 extra cycles in DONE → hilo_we_o high exactly one cycle, ready_o held, IDLE one cycle after start_i drops.

Source files
------------

// File: rtl/div_hilo_seq.sv
// Multi-cycle restoring divider feeding the HI/LO pair: result = {remainder, quotient}.
// Optional macro DIV_BYZERO_EN adds a short BYZERO path for a zero divisor.
module div_hilo_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic                  stall_o,
  output logic                  ready_o,
  output logic                  hilo_we_o,
  output logic [2*DATA_W-1:0]   result_o
);

  // state  | meaning
  // IDLE   | waiting for a request
  // ON     | one shift-subtract iteration per cycle
  // DONE   | result held, ready_o high until start_i drops
  // BYZERO | zero divisor shortcut (DIV_BYZERO_EN only)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON     = 2'd1,
    DONE   = 2'd2
`ifdef DIV_BYZERO_EN
    ,BYZERO = 2'd3
`endif
  } state_t;

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    divisor;
  logic [2*DATA_W:0]    rem;
  logic                 neg_q, neg_r;

  logic                 accept, last;
  logic [DATA_W-1:0]    a_abs, b_abs;
  logic [2*DATA_W:0]    shifted, rem_nxt;
  logic [DATA_W:0]      diff;
  logic [DATA_W-1:0]    quo_fix, rmd_fix;

  assign accept  = (state == IDLE) && start_i && !annul_i;
  assign last    = (cnt == CNT_W'(DATA_W - 1));
  assign a_abs   = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign b_abs   = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Upper DATA_W+1 bits hold the partial remainder; lower half shifts dividend out and quotient in.
  assign shifted = {rem[2*DATA_W-1:0], 1'b0};
  assign diff    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
  assign rem_nxt = diff[DATA_W] ? shifted : {diff, shifted[DATA_W-1:1], 1'b1};
  assign quo_fix = neg_q ? -rem_nxt[DATA_W-1:0] : rem_nxt[DATA_W-1:0];
  assign rmd_fix = neg_r ? -rem_nxt[2*DATA_W-1:DATA_W] : rem_nxt[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o   = 1'b1;
          state_nxt = ON;
`ifdef DIV_BYZERO_EN
          if (opdata2_i == '0) state_nxt = BYZERO;
`endif
        end
      end
      ON: begin
        stall_o = 1'b1;
        if (annul_i)   state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
`ifdef DIV_BYZERO_EN
      BYZERO: begin
        stall_o   = 1'b1;
        state_nxt = annul_i ? IDLE : DONE;
      end
`endif
      DONE: begin
        if (!start_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      divisor   <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ready_o   <= 1'b0;
      hilo_we_o <= 1'b0;
      result_o  <= '0;
    end else begin
      hilo_we_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            divisor <= b_abs;
            rem     <= {{(DATA_W+1){1'b0}}, a_abs};
            neg_q   <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r   <= signed_i && opdata1_i[DATA_W-1];
          end
        end
        ON: begin
          if (!annul_i) begin
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
              result_o  <= {rmd_fix, quo_fix};
              ready_o   <= 1'b1;
              hilo_we_o <= 1'b1;
            end
          end
        end
`ifdef DIV_BYZERO_EN
        BYZERO: begin
          if (!annul_i) begin
            result_o  <= '0;
            ready_o   <= 1'b1;
            hilo_we_o <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
